// File: rtl/frame_buf_arbiter.sv
// frame_buf_arbiter: N-channel round-robin burst scheduler for the SDRAM
// frame buffer. Picks one eligible channel at a time, presents a burst
// request to the command engine and advances the channel's wrapping address
// once the engine reports the burst done.
// Optional build macro: FRAME_BUF_PINGPONG_EN (bank ping-pong between the
// frame being written and the frame being displayed, bank in req_addr[AW-1]).
// Handshake: req_valid rises with all req_* fields already registered; the
// fields hold steady until the cycle where req_valid & req_ready are both
// high, after which req_valid drops and the block waits for burst_done.
module frame_buf_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int AW         = 24,
    parameter int LW         = 9,
    parameter int FW         = 10,
    parameter int FIFO_DEPTH = 512
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic [NUM_CH-1:0]    ch_write,
    input  logic [NUM_CH*AW-1:0] ch_base,
    input  logic [NUM_CH*AW-1:0] ch_max,
    input  logic [NUM_CH*LW-1:0] ch_len,
    input  logic [NUM_CH*FW-1:0] ch_level,
    input  logic [NUM_CH-1:0]    ch_load,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [AW-1:0]        req_addr,
    output logic [LW-1:0]        req_len,
    output logic                 req_write,
    output logic [2:0]           req_ch,
    input  logic                 burst_done,
    output logic [NUM_CH-1:0]    ch_grant,
    output logic [NUM_CH-1:0]    ch_wrap,
    output logic [1:0]           dbg_state
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef FRAME_BUF_PINGPONG_EN
    localparam int LAW = AW - 1;   // top address bit is the bank select
`else
    localparam int LAW = AW;
`endif
    localparam int NW = LAW + 1;   // address sum width, keeps the carry
    localparam int SW = FW + 1;    // FIFO room sum width

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_BUSY = 2'd2} state_t;

    state_t            state_q;
    logic [LAW-1:0]    addr_q [NUM_CH];
    logic              load_pend_q;
    logic [CW-1:0]     rr_q;
    logic [CW-1:0]     srv_q;
    logic              req_valid_q;
    logic              req_write_q;
    logic [AW-1:0]     req_addr_q;
    logic [LW-1:0]     req_len_q;
    logic [NUM_CH-1:0] grant_q;
    logic [NUM_CH-1:0] wrap_q;

    logic [LAW-1:0]    base_d [NUM_CH];
    logic [LAW-1:0]    max_d  [NUM_CH];
    logic [NUM_CH-1:0] elig_d;
    logic [NUM_CH-1:0] svc_d;
    logic              win_found_d;
    logic [CW-1:0]     win_d;
    logic [LAW-1:0]    win_addr_d;
    logic [AW-1:0]     win_req_addr_d;
    logic [NW-1:0]     nxt_d;
    logic              restart_d;
    logic              wrap_hit_d;

    // Per-channel window bounds, eligibility and in-service flags
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            base_d[i] = ch_base[i*AW +: LAW];
            max_d[i]  = ch_max[i*AW +: LAW];
            svc_d[i]  = (state_q != S_IDLE) && (srv_q == CW'(i));
            if (ch_write[i])
                elig_d[i] = ch_en[i] && (ch_len[i*LW +: LW] != '0) &&
                            (SW'(ch_level[i*FW +: FW]) >= SW'(ch_len[i*LW +: LW]));
            else
                elig_d[i] = ch_en[i] && (ch_len[i*LW +: LW] != '0) &&
                            ((SW'(ch_level[i*FW +: FW]) + SW'(ch_len[i*LW +: LW])) <= SW'(FIFO_DEPTH));
        end
    end

    // Round-robin search from rr_q; descending scan so the nearest channel wins
    always_comb begin
        win_found_d = 1'b0;
        win_d       = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            int idx;
            idx = (int'(rr_q) + k) % NUM_CH;
            if (elig_d[idx]) begin
                win_found_d = 1'b1;
                win_d       = CW'(idx);
            end
        end
    end

    // Winner start address (a load in the grant cycle restarts at base) and
    // the served channel's next address / restart decision
    always_comb begin
        win_addr_d = ch_load[win_d] ? base_d[win_d] : addr_q[win_d];
        nxt_d      = {1'b0, addr_q[srv_q]} + NW'(req_len_q);
        restart_d  = load_pend_q | ch_load[srv_q];
        wrap_hit_d = !restart_d && (nxt_d >= {1'b0, max_d[srv_q]});
    end

`ifdef FRAME_BUF_PINGPONG_EN
    logic              wr_bank_q;
    logic [NUM_CH-1:0] rd_bank_q;
    logic [CW-1:0]     first_wr_d;
    logic              win_bank_d;

    // Lowest-indexed write channel owns the write bank toggle
    always_comb begin
        first_wr_d = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (ch_write[i]) first_wr_d = CW'(i);
        if (ch_write[win_d])
            win_bank_d = wr_bank_q;
        else
            win_bank_d = ch_load[win_d] ? ~wr_bank_q : rd_bank_q[win_d];
        win_req_addr_d = {win_bank_d, win_addr_d};
    end

    // Bank tracking: writers flip wr_bank on wrap, readers follow the finished frame
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank_q <= 1'b0;
            rd_bank_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (ch_load[i] && !ch_write[i] && !svc_d[i]) rd_bank_q[i] <= ~wr_bank_q;
            if (state_q == S_BUSY && burst_done) begin
                if (restart_d) begin
                    if (!ch_write[srv_q]) rd_bank_q[srv_q] <= ~wr_bank_q;
                end else if (wrap_hit_d) begin
                    if (!ch_write[srv_q]) rd_bank_q[srv_q] <= ~wr_bank_q;
                    else if (srv_q == first_wr_d) wr_bank_q <= ~wr_bank_q;
                end
            end
        end
    end
`else
    // Linear addressing: request address is the channel address itself
    always_comb begin
        win_req_addr_d = win_addr_d;
    end
`endif

    // Scheduler FSM: IDLE picks a winner, REQ holds the request, BUSY waits for completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_len_q   <= '0;
            req_write_q <= 1'b0;
            srv_q       <= '0;
            grant_q     <= '0;
            wrap_q      <= '0;
            rr_q        <= '0;
            load_pend_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) addr_q[i] <= '0;
        end else begin
            wrap_q <= '0;
            for (int i = 0; i < NUM_CH; i++)
                if (ch_load[i] && !svc_d[i]) addr_q[i] <= base_d[i];
            case (state_q)
                S_IDLE: begin
                    if (win_found_d) begin
                        state_q     <= S_REQ;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= win_req_addr_d;
                        req_len_q   <= ch_len[win_d*LW +: LW];
                        req_write_q <= ch_write[win_d];
                        srv_q       <= win_d;
                        grant_q     <= NUM_CH'(1) << win_d;
                        load_pend_q <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (ch_load[srv_q]) load_pend_q <= 1'b1;
                    if (req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (ch_load[srv_q]) load_pend_q <= 1'b1;
                    if (burst_done) begin
                        if (restart_d || wrap_hit_d) addr_q[srv_q] <= base_d[srv_q];
                        else addr_q[srv_q] <= nxt_d[LAW-1:0];
                        if (wrap_hit_d) wrap_q[srv_q] <= 1'b1;
                        rr_q        <= (srv_q == CW'(NUM_CH - 1)) ? '0 : srv_q + 1'b1;
                        grant_q     <= '0;
                        load_pend_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_valid = req_valid_q;
    assign req_addr  = req_addr_q;
    assign req_len   = req_len_q;
    assign req_write = req_write_q;
    assign req_ch    = 3'(srv_q);
    assign ch_grant  = grant_q;
    assign ch_wrap   = wrap_q;
    assign dbg_state = state_q;

endmodule

// File: doc/frame_buf_arbiter.md
Name: frame_buf_arbiter

Overview:
- Parametrised N-channel burst scheduler for the SDRAM frame buffer; successor to the fixed 2-write/2-read port front end of the 4-port SDRAM controller.
- Each channel has a direction, window (base/max), burst length and FIFO fill level. The block round-robins among channels ready for a burst, generates linear wrapping addresses, and hands one burst at a time to the SDRAM command engine.
- Sits in the CTRL_CLK domain between the per-channel CDC FIFOs and the SDRAM command/data engine.

Parameters:
- NUM_CH, 4, number of channels (2..8).
- AW, 24, SDRAM word-address width.
- LW, 9, burst-length width (max burst 256).
- FW, 10, FIFO level width.
- FIFO_DEPTH, 512, per-channel FIFO depth in words (read-room check).

Ports:
- clk  in  1  controller clock.
- rst  in  1  synchronous reset, active-high.
- ch_en  in  NUM_CH  channel enable.
- ch_write  in  NUM_CH  1 = channel writes SDRAM (camera side), 0 = reads SDRAM (display side).
- ch_base  in  NUM_CH*AW  window start address, channel i at [i*AW +: AW].
- ch_max  in  NUM_CH*AW  window end, exclusive.
- ch_len  in  NUM_CH*LW  burst length in words.
- ch_level  in  NUM_CH*FW  FIFO words held.
- ch_load  in  NUM_CH  1-cycle pulse: restart channel at base.
- req_valid  out  1  burst request.
- req_ready  in  1  engine accepts request.
- req_addr  out  AW  burst start address.
- req_len  out  LW  burst length.
- req_write  out  1  burst direction.
- req_ch  out  3  served channel index.
- burst_done  in  1  1-cycle pulse: engine finished the burst.
- ch_grant  out  NUM_CH  one-hot FIFO steering, valid from REQ through BUSY.
- ch_wrap  out  NUM_CH  1-cycle pulse when a channel wraps to base.

Behaviour:
- Reset values:
  - Outputs: req_valid=0, req_addr=0, req_len=0, req_write=0, req_ch=0, ch_grant=0, ch_wrap=0.
  - Internal: per-channel addr=0; RR pointer=0; FSM in IDLE.
- Eligibility (combinational), channel i is eligible when all of:
  - ch_en[i]=1 and len_i != 0.
  - Write channel: level_i >= len_i.
  - Read channel: level_i + len_i <= FIFO_DEPTH, summed at FW+1 bits.
- Arbitration: round-robin. Search starts at (last served + 1) mod NUM_CH; after reset channel 0 has top priority.
- FSM:
  - IDLE: if any channel is eligible, register the winner (req_addr=addr_i, req_len, req_write, req_ch, ch_grant) and go to REQ. Request appears the cycle after eligibility.
  - REQ: hold req_valid=1 with all req_* stable until req_valid&req_ready; then go to BUSY (req_valid=0 next cycle).
  - BUSY: wait for burst_done.
    - Next address: nxt = addr+len at AW+1 bits.
    - If nxt >= max_i: addr <= base_i and pulse ch_wrap[i] for 1 cycle; otherwise addr <= nxt.
    - Advance the RR pointer; clear ch_grant; return to IDLE.
  - Minimum spacing between successive requests: 1 IDLE cycle.
- ch_load handling:
  - Channel not in service: addr <= base next cycle.
  - Channel in service (REQ/BUSY): set a pending flag; at burst_done set addr <= base instead of nxt, with no ch_wrap pulse.
  - The in-flight burst is never aborted.
- Other boundary cases:
  - burst_done outside BUSY is ignored.
  - ch_en dropping while the channel is in service: the burst completes normally.
  - base >= max: channel restarts at base after every burst.
  - rst mid-burst: FSM returns to IDLE, req_valid=0 immediately; the engine is reset by the same rst.
  - Level changes during REQ/BUSY do not alter the latched request.

Optional Feature:
- FRAME_BUF_PINGPONG_EN defined:
  - req_addr[AW-1] is a bank bit; base/max/addr use AW-1 bits.
  - A global wr_bank toggles whenever the lowest-indexed write channel wraps.
  - Write channels use wr_bank; read channels latch ~wr_bank at their own wrap or load.
  - Net effect: display reads only a completed frame, never the one being written.
  - wr_bank resets to 0.
- Undefined: req_addr = addr, full AW linear, no bank logic.

Test Plan:
- Single write ch0 (base 0, max 1024, len 256), level 256 -> req addr 0, 256, 512, 768, then 0 with ch_wrap[0] pulse after the 4th burst_done.
- Read ch2, len 256, level 300 -> not eligible; level 256 -> eligible, req_write=0.
- ch0, ch1, ch3 all eligible continuously -> grant order 0,1,3,0,1,3; req_valid gap exactly 1 cycle after each burst_done.
- ch_load[0] pulsed in BUSY at addr 512 -> burst completes; next ch0 req_addr=0 (base), no ch_wrap.
- req_ready held low 20 cycles -> req_valid and req_* stable for 20 cycles; rst asserted at cycle 10 -> req_valid=0 the following cycle; all addresses 0.
- FRAME_BUF_PINGPONG_EN: write ch0 wraps twice -> wr_bank 0→1→0; read ch1 wrapping after the first wrap issues addresses with bit AW-1=0.
